// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32I encodings used by the memory stage:
//   - funct3 load/store size/sign codes (F3_*)
//   - writeback result-source codes (RES_*)
//   - load_extend(): picks the byte/half selected by the low address bits
//     out of a 32-bit memory word and sign- or zero-extends it.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Extract and extend load data. Undefined funct3 codes return zero;
    // callers treat them as faulting accesses anyway.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'h0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'h0, h};
            F3_W:    res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem
// Word-organised, byte-writable data memory with combinational read.
// Ports:
//   clk    in   rising-edge clock for writes
//   we     in   write strobe (already qualified by caller)
//   be     in   4  per-byte write enables, bit i -> bits [8i+7:8i]
//   addr   in   AW word index
//   wdata  in   32 lane-aligned write data
//   rdata  out  32 word at addr (reflects contents before the current edge)
// Contents are never reset.
module data_mem #(
    parameter int    DMEM_WORDS = 1024,
    parameter string DMEM_INIT  = "",
    localparam int   AW         = $clog2(DMEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage
// M stage of the five-stage RV32I pipeline plus the MEM/WB register.
// Performs loads/stores on an internal little-endian data memory; load data
// is extracted/extended and registered with the pass-through fields.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ALUResultM  in  32  effective address or ALU result
//   WriteDataM  in  32  store data
//   PCPlus4M    in  32  PC+4 of instruction in M
//   RdM         in  5   destination register
//   RegWriteM   in  1   instruction writes rd
//   MemWriteM   in  1   store
//   ResultSrcM  in  2   RES_ALU / RES_MEM (load) / RES_PC4
//   funct3M     in  3   access size/sign
//   *W          out     registered copies for the writeback mux;
//                       ReadDataW is extended load data (0 if not a good load),
//                       MisalignW flags a misaligned or undefined-size access.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int    DMEM_WORDS = 1024,
    parameter string DMEM_INIT  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MisalignW
);

    localparam int AW = $clog2(DMEM_WORDS);

    logic          is_load;
    logic          is_store;
    logic          bad_align;
    logic          misaligned;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   load_data;
    logic [AW-1:0] word_addr;
    logic [1:0]    off;
    logic          regwrite_q;

    assign is_load   = (ResultSrcM == RES_MEM);
    assign is_store  = MemWriteM;
    assign off       = ALUResultM[1:0];
    // Upper address bits are dropped so out-of-range addresses alias.
    assign word_addr = ALUResultM[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUResultM[31:AW+2];

    // Alignment check; undefined sizes are reported as misaligned.
    always_comb begin
        bad_align = 1'b1;
        case (funct3M)
            F3_B, F3_BU: bad_align = 1'b0;
            F3_H, F3_HU: bad_align = off[0];
            F3_W:        bad_align = (off != 2'b00);
            default:     bad_align = 1'b1;
        endcase
    end

    assign misaligned = (is_load | is_store) & bad_align;

    // Byte enables and lane replication: replicating the data across lanes
    // lets the byte enables alone select where it lands.
    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = WriteDataM;
        case (funct3M)
            F3_B: begin
                mem_be    = 4'b0001 << off;
                mem_wdata = {4{WriteDataM[7:0]}};
            end
            F3_H: begin
                mem_be    = off[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{WriteDataM[15:0]}};
            end
            F3_W: begin
                mem_be    = 4'b1111;
                mem_wdata = WriteDataM;
            end
            default: begin
                mem_be    = 4'b0000;
                mem_wdata = WriteDataM;
            end
        endcase
    end

    // A store coinciding with reset is dropped.
    assign mem_we = is_store & ~misaligned & ~rst;

    data_mem #(
        .DMEM_WORDS (DMEM_WORDS),
        .DMEM_INIT  (DMEM_INIT)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (word_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign load_data = (is_load & ~misaligned) ? load_extend(funct3M, off, mem_rdata) : 32'h0;

    // A faulting load must not write the register file; x0 is never written.
    assign regwrite_q = RegWriteM & ~(is_load & misaligned) & (RdM != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            RdW        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
            MisalignW  <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= regwrite_q;
            ResultSrcW <= ResultSrcM;
            MisalignW  <= misaligned;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    localparam int W = 105;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] PCPlus4M = '0;
    logic [4:0]  RdM = '0;
    logic        RegWriteM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [1:0]  ResultSrcM = '0;
    logic [2:0]  funct3M = '0;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        MisalignW;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .MisalignW  (MisalignW)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           failures = 0;
    logic         issued = 1'b0;
    logic         issued_d = 1'b0;
    int           pc = 0;

    // An instruction driven before edge N is visible on W outputs after N.
    always @(posedge clk) issued_d <= issued;

    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        if (issued_d) begin
            act_v = {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL no_expected: output with empty queue act=%h", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s: act alu=%h rd=%h pc4=%h rdW=%0d rw=%b rs=%b mis=%b  exp alu=%h rd=%h pc4=%h rdW=%0d rw=%b rs=%b mis=%b",
                             nm, act_v[104:73], act_v[72:41], act_v[40:9], act_v[8:4], act_v[3], act_v[2:1], act_v[0],
                             exp_v[104:73], exp_v[72:41], exp_v[40:9], exp_v[8:4], exp_v[3], exp_v[2:1], exp_v[0]);
                end
            end
        end
    end

    // driver: present one instruction for one cycle and push its expected W image
    task automatic op(input string nm, input logic r, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                      input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                      input logic [31:0] e_rdata, input logic e_rw, input logic e_mis);
        logic [31:0] pc4;
        pc  = pc + 4;
        pc4 = 32'h1000 + pc;
        rst = r; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
        issued = 1'b1;
        if (r) exp_q.push_back('0);
        else   exp_q.push_back({alu, e_rdata, pc4, rd, e_rw, rs, e_mis});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        //  name        rst alu           wdata         rd  rw mw rs     f3      exp_rdata     rw mis
        op("sw_beef",   0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1, 2'b00, 3'b010, 32'h0,        0, 0);
        op("rst1",      1, 32'h0000_0000, 32'h1111_1111, 7, 1, 1, 2'b01, 3'b010, 32'h0,        0, 0);
        op("rst2",      1, 32'hFFFF_FFFF, 32'h2222_2222, 9, 1, 0, 2'b10, 3'b000, 32'h0,        0, 0);
        op("lw_beef",   0, 32'h0000_0000, 32'h0,         1, 1, 0, 2'b01, 3'b010, 32'hDEAD_BEEF, 1, 0);
        op("sw_10",     0, 32'h0000_0010, 32'h1234_5678, 0, 0, 1, 2'b00, 3'b010, 32'h0,        0, 0);
        op("lw_10",     0, 32'h0000_0010, 32'h0,         2, 1, 0, 2'b01, 3'b010, 32'h1234_5678, 1, 0);
        op("lb_13",     0, 32'h0000_0013, 32'h0,         2, 1, 0, 2'b01, 3'b000, 32'h0000_0012, 1, 0);
        op("sb_11",     0, 32'h0000_0011, 32'hABCD_EF80, 0, 0, 1, 2'b00, 3'b000, 32'h0,        0, 0);
        op("lb_11",     0, 32'h0000_0011, 32'h0,         3, 1, 0, 2'b01, 3'b000, 32'hFFFF_FF80, 1, 0);
        op("lbu_11",    0, 32'h0000_0011, 32'h0,         3, 1, 0, 2'b01, 3'b100, 32'h0000_0080, 1, 0);
        op("lh_10",     0, 32'h0000_0010, 32'h0,         4, 1, 0, 2'b01, 3'b001, 32'hFFFF_8078, 1, 0);
        op("lhu_10",    0, 32'h0000_0010, 32'h0,         4, 1, 0, 2'b01, 3'b101, 32'h0000_8078, 1, 0);
        op("sw_mis_12", 0, 32'h0000_0012, 32'hCAFE_F00D, 0, 0, 1, 2'b00, 3'b010, 32'h0,        0, 1);
        op("lw_10_chk", 0, 32'h0000_0010, 32'h0,         6, 1, 0, 2'b01, 3'b010, 32'h1234_8078, 1, 0);
        op("lh_mis_11", 0, 32'h0000_0011, 32'h0,         3, 1, 0, 2'b01, 3'b001, 32'h0,        0, 1);
        op("sw_20",     0, 32'h0000_0020, 32'h1111_2222, 0, 0, 1, 2'b00, 3'b010, 32'h0,        0, 0);
        op("sw_20_rst", 1, 32'h0000_0020, 32'hAAAA_5555, 0, 0, 1, 2'b00, 3'b010, 32'h0,        0, 0);
        op("lw_20",     0, 32'h0000_0020, 32'h0,         8, 1, 0, 2'b01, 3'b010, 32'h1111_2222, 1, 0);
        op("alu_pass",  0, 32'h0000_0007, 32'h0,         5, 1, 0, 2'b00, 3'b000, 32'h0,        1, 0);
        op("alu_x0",    0, 32'h0000_0009, 32'h0,         0, 1, 0, 2'b00, 3'b000, 32'h0,        0, 0);
        op("pc4_pass",  0, 32'h0000_0044, 32'h0,        10, 1, 0, 2'b10, 3'b000, 32'h0,        1, 0);
        op("sh_22",     0, 32'h0000_0022, 32'h1234_BEEF, 0, 0, 1, 2'b00, 3'b001, 32'h0,        0, 0);
        op("lw_20_sh",  0, 32'h0000_0020, 32'h0,        11, 1, 0, 2'b01, 3'b010, 32'hBEEF_2222, 1, 0);
        op("lhu_22",    0, 32'h0000_0022, 32'h0,        11, 1, 0, 2'b01, 3'b101, 32'h0000_BEEF, 1, 0);
        op("lh_22",     0, 32'h0000_0022, 32'h0,        11, 1, 0, 2'b01, 3'b001, 32'hFFFF_BEEF, 1, 0);
        op("sw_wrap",   0, 32'h0000_1030, 32'h5A5A_5A5A, 0, 0, 1, 2'b00, 3'b010, 32'h0,        0, 0);
        op("lw_30",     0, 32'h0000_0030, 32'h0,        12, 1, 0, 2'b01, 3'b010, 32'h5A5A_5A5A, 1, 0);
        op("st_ld_30",  0, 32'h0000_0030, 32'h7777_7777, 13, 1, 1, 2'b01, 3'b010, 32'h5A5A_5A5A, 1, 0);
        op("lw_30_new", 0, 32'h0000_0030, 32'h0,        13, 1, 0, 2'b01, 3'b010, 32'h7777_7777, 1, 0);
        op("ld_f3_bad", 0, 32'h0000_0030, 32'h0,        14, 1, 0, 2'b01, 3'b011, 32'h0,        0, 1);
        op("lw_mis_21", 0, 32'h0000_0021, 32'h0,        15, 1, 0, 2'b01, 3'b010, 32'h0,        0, 1);

        // idle and drain
        issued = 1'b0;
        rst = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; RegWriteM = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: leftover expected entries act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
